// File: rtl/smj_pkg.sv
// Shared types, class codes and helpers for the SMJ test-hand dealer.
package smj_pkg;

  // One tile: suit 00 = honor (rank 0-6), suits 01/10/11 = numbers (rank 0-8).
  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } tile_t;

  // Five-tile hand, element 0 is the first tile built.
  typedef tile_t [4:0] hand_t;

  localparam logic [1:0] SMJ_NOWIN   = 2'b00;
  localparam logic [1:0] SMJ_INVALID = 2'b01;
  localparam logic [1:0] SMJ_SEQPAIR = 2'b10;
  localparam logic [1:0] SMJ_TRIPAIR = 2'b11;

  localparam logic [1:0] SUIT_HONOR     = 2'b00;
  localparam logic [3:0] RANK_MAX_HONOR = 4'd6;
  localparam logic [3:0] RANK_MAX_NUM   = 4'd8;

  // 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting left.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Fold a raw 4-bit rank into the legal range of the given suit.
  function automatic logic [3:0] rank_mod(input logic [1:0] suit, input logic [3:0] rank);
    if (suit == SUIT_HONOR) return rank % (RANK_MAX_HONOR + 4'd1);
    else                    return rank % (RANK_MAX_NUM + 4'd1);
  endfunction

  // (a + d) mod 9 without overflowing 4 bits.
  function automatic logic [3:0] add_mod9(input logic [3:0] a, input logic [3:0] d);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, d};
    s = s % 5'd9;
    return s[3:0];
  endfunction

  function automatic tile_t mk_tile(input logic [1:0] suit, input logic [3:0] rank);
    tile_t t;
    t.suit = suit;
    t.rank = rank;
    return t;
  endfunction

endpackage

// File: rtl/smj_hand_build.sv
// Combinational hand constructor: (class, stepped LFSR) -> five tiles plus emit rotation.
module smj_hand_build
  import smj_pkg::*;
(
  input  logic [1:0]  hand_class,
  input  logic [15:0] lfsr,
  output hand_t       hand,
  output logic [2:0]  rot
);

  logic [1:0] sa, sp, s_num;
  logic [3:0] ra, rb, seq_r, nw_b;
  logic       flav;
  tile_t      trip, pair_raw, pair;

  assign sa   = lfsr[1:0];
  assign ra   = lfsr[5:2];
  assign rb   = lfsr[9:6];
  assign flav = lfsr[13];
  assign sp   = lfsr[15:14];

  // Sequences and no-win runs need a number suit; honors are remapped to suit 01.
  assign s_num    = (sa == SUIT_HONOR) ? 2'b01 : sa;
  assign seq_r    = ra % 4'd7;
  assign nw_b     = ra % 4'd9;
  assign trip     = mk_tile(sa, rank_mod(sa, ra));
  assign pair_raw = mk_tile(sp, rank_mod(sp, rb));
  assign rot      = (lfsr[12:10] >= 3'd5) ? (lfsr[12:10] - 3'd5) : lfsr[12:10];

  // Build the hand for the requested class, nudging the pair off any colliding tile.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    hand = '0;
    pair = pair_raw;
    case (hand_class)
      SMJ_TRIPAIR: begin
        if (pair == trip) pair.rank = rank_mod(sp, pair.rank + 4'd1);
        hand[0] = trip;
        hand[1] = trip;
        hand[2] = trip;
        hand[3] = pair;
        hand[4] = pair;
      end
      SMJ_SEQPAIR: begin
        for (int i = 0; i < 3; i++) hand[i] = mk_tile(s_num, seq_r + 4'(i));
        if (pair == hand[0] || pair == hand[1] || pair == hand[2])
          pair = mk_tile(s_num, add_mod9(seq_r, 4'd3));
        hand[3] = pair;
        hand[4] = pair;
      end
      SMJ_NOWIN: begin
        for (int i = 0; i < 5; i++) hand[i] = mk_tile(s_num, add_mod9(nw_b, 4'(2 * i)));
      end
      default: begin
        if (!flav) begin
          for (int i = 0; i < 5; i++) hand[i] = mk_tile(s_num, add_mod9(nw_b, 4'(2 * i)));
          hand[0] = mk_tile(sa, 4'hF);
        end else begin
          for (int i = 0; i < 5; i++) hand[i] = trip;
        end
      end
    endcase
  end

endmodule

// File: rtl/smj_hand_gen.sv
// SMJ test-hand dealer: accepts a requested class and streams a matching 5-tile hand.
module smj_hand_gen
  import smj_pkg::*;
#(
  parameter logic [15:0] LFSR_RST = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        req_valid,
  input  logic [1:0]  req_class,
  output logic        req_ready,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [5:0]  tile_data,
  output logic        tile_last,
  output logic [1:0]  tile_class
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUILD = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  logic [1:0]  state;
  logic [15:0] lfsr;
  logic [1:0]  class_q;
  hand_t       hand_q, hand_d;
  logic [2:0]  rot_q, rot_d;
  logic [2:0]  k_q;
  logic [3:0]  pos_sum;
  logic [2:0]  idx;

  smj_hand_build u_build (
    .hand_class (class_q),
    .lfsr       (lfsr),
    .hand       (hand_d),
    .rot        (rot_d)
  );

  // Emission slot (rot + k) mod 5; both terms are at most 4.
  assign pos_sum = {1'b0, rot_q} + {1'b0, k_q};
  assign idx     = (pos_sum >= 4'd5) ? 3'(pos_sum - 4'd5) : pos_sum[2:0];

  assign req_ready  = ~rst & (state == ST_IDLE) & ~seed_load;
  assign tile_valid = (state == ST_EMIT);
  assign tile_last  = tile_valid & (k_q == 3'd4);
  assign tile_data  = hand_q[idx];
  assign tile_class = class_q;

  // FSM, LFSR, hand buffer and emit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state   <= ST_IDLE;
      lfsr    <= LFSR_RST;
      class_q <= SMJ_NOWIN;
      // NOTE: the five-entry hand buffer is reset so tile_data reads zero out of reset.
      hand_q  <= '0;
      rot_q   <= '0;
      k_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (seed_load) begin
            lfsr <= (seed == 16'h0000) ? 16'h0001 : seed;
          end else if (req_valid) begin
            lfsr    <= lfsr_step(lfsr);
            class_q <= req_class;
            state   <= ST_BUILD;
          end
        end
        ST_BUILD: begin
          hand_q <= hand_d;
          rot_q  <= rot_d;
          k_q    <= '0;
          state  <= ST_EMIT;
        end
        ST_EMIT: begin
          if (tile_ready) begin
            if (k_q == 3'd4) begin
              k_q   <= '0;
              state <= ST_IDLE;
            end else begin
              k_q <= k_q + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smj_hand_gen.sv
// Self-checking bench for smj_hand_gen: directed cases plus random hands scored by a judge model.
module tb_smj_hand_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_class = '0;
  logic        req_ready;
  logic        tile_valid;
  logic        tile_ready = 1'b0;
  logic [5:0]  tile_data;
  logic        tile_last;
  logic [1:0]  tile_class;

  int tests = 0;
  int fails = 0;
  logic [15:0] model_lfsr;
  int hand_tiles[5];

  smj_hand_gen dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed       (seed),
    .req_valid  (req_valid),
    .req_class  (req_class),
    .req_ready  (req_ready),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_data  (tile_data),
    .tile_last  (tile_last),
    .tile_class (tile_class)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // LFSR next value from the shift/feedback rule, in plain arithmetic.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int x, fb;
    x  = int'(v);
    fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    return 16'(((x << 1) & 'hFFFF) | fb);
  endfunction

  function automatic int rng(input int suit);
    return (suit == 0) ? 7 : 9;
  endfunction

  // Expected tiles in emission order, packed 6 bits per tile (tile 0 in the low bits).
  function automatic logic [29:0] model_hand(input logic [15:0] lp, input logic [1:0] cls);
    int l, sa, ra, rb, rot, flav, sp, s, r, b, t, p;
    int h[5];
    logic [29:0] res;
    l = int'(lp);
    sa = l % 4; ra = (l / 4) % 16; rb = (l / 64) % 16;
    rot = ((l / 1024) % 8) % 5; flav = (l / 8192) % 2; sp = l / 16384;
    s = (sa == 0) ? 1 : sa;
    case (cls)
      2'b11: begin
        t = sa * 16 + ra % rng(sa);
        p = sp * 16 + rb % rng(sp);
        if (p == t) p = sp * 16 + ((rb % rng(sp)) + 1) % rng(sp);
        h = '{t, t, t, p, p};
      end
      2'b10: begin
        r = ra % 7;
        p = sp * 16 + rb % rng(sp);
        if (p == s * 16 + r || p == s * 16 + r + 1 || p == s * 16 + r + 2)
          p = s * 16 + (r + 3) % 9;
        h = '{s * 16 + r, s * 16 + r + 1, s * 16 + r + 2, p, p};
      end
      2'b00: begin
        b = ra % 9;
        for (int i = 0; i < 5; i++) h[i] = s * 16 + (b + 2 * i) % 9;
      end
      default: begin
        if (flav == 0) begin
          b = ra % 9;
          for (int i = 0; i < 5; i++) h[i] = s * 16 + (b + 2 * i) % 9;
          h[0] = sa * 16 + 15;
        end else begin
          for (int i = 0; i < 5; i++) h[i] = sa * 16 + ra % rng(sa);
        end
      end
    endcase
    res = '0;
    for (int k = 0; k < 5; k++) res[6 * k +: 6] = 6'(h[(rot + k) % 5]);
    return res;
  endfunction

  // SMJ judge: scores any 5-tile hand independently of how it was built.
  function automatic int judge(input int t[5]);
    int cnt[64];
    int rest[3];
    int n, removed, tmp, su;
    bit trip, pair;
    trip = 0; pair = 0;
    for (int v = 0; v < 64; v++) cnt[v] = 0;
    for (int i = 0; i < 5; i++) begin
      su = t[i] / 16;
      if ((t[i] % 16) > ((su == 0) ? 6 : 8)) return 1;
      cnt[t[i]]++;
    end
    for (int v = 0; v < 64; v++) begin
      if (cnt[v] > 4) return 1;
      if (cnt[v] == 3) trip = 1;
      if (cnt[v] == 2) pair = 1;
    end
    if (trip && pair) return 3;
    for (int v = 0; v < 64; v++) begin
      if (cnt[v] >= 2) begin
        n = 0; removed = 0;
        for (int i = 0; i < 5; i++) begin
          if (t[i] == v && removed < 2) removed++;
          else if (n < 3) begin rest[n] = t[i]; n++; end
        end
        for (int a = 0; a < 2; a++)
          for (int c = 0; c < 2 - a; c++)
            if (rest[c] > rest[c + 1]) begin
              tmp = rest[c]; rest[c] = rest[c + 1]; rest[c + 1] = tmp;
            end
        if (rest[0] / 16 != 0 && rest[1] == rest[0] + 1 && rest[2] == rest[0] + 2) return 2;
      end
    end
    return 0;
  endfunction

  task automatic load_seed(input logic [15:0] s);
    seed_load = 1'b1;
    seed = s;
    #1;
    check("seed_load_blocks_req", req_ready, 1'b0);
    step();
    seed_load = 1'b0;
    model_lfsr = (s == 16'h0000) ? 16'h0001 : s;
  endtask

  // bp: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles on tile 2.
  task automatic get_hand(input logic [1:0] cls, input int bp, output int tiles[5]);
    logic [29:0] exp;
    logic [5:0]  prev_d;
    logic        prev_hold;
    int got, cyc, low_left;
    for (int i = 0; i < 5; i++) tiles[i] = 0;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin step(); cyc++; end
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_class = cls;
    step();
    req_valid = 1'b0;
    req_class = 2'($urandom);
    model_lfsr = lfsr_next(model_lfsr);
    exp = model_hand(model_lfsr, cls);
    check("build_cycle_no_valid", tile_valid, 1'b0);
    step();
    check("first_valid_n_plus_2", tile_valid, 1'b1);
    got = 0; cyc = 0; prev_hold = 1'b0; prev_d = '0; low_left = 3;
    while (got < 5 && cyc < 100) begin
      if (bp == 1) tile_ready = 1'($urandom_range(0, 1));
      else if (bp == 2 && got == 1 && low_left > 0) begin tile_ready = 1'b0; low_left--; end
      else tile_ready = 1'b1;
      #1;
      if (prev_hold) begin
        check("hold_valid", tile_valid, 1'b1);
        check("hold_data", tile_data, prev_d);
      end
      if (tile_valid && tile_ready) begin
        check("tile_data", tile_data, exp[6 * got +: 6]);
        check("tile_last", tile_last, (got == 4));
        check("tile_class", tile_class, cls);
        tiles[got] = int'(tile_data);
        got++;
      end
      prev_hold = tile_valid && !tile_ready;
      prev_d = tile_data;
      step();
      cyc++;
    end
    check("hand_complete", got, 5);
    check("req_ready_after_last", req_ready, 1'b1);
    check("judge_vs_class", judge(tiles), cls);
  endtask

  task automatic check_tiles(input string tag, input int exp0, input int exp1,
                             input int exp2, input int exp3, input int exp4);
    int e[5];
    e = '{exp0, exp1, exp2, exp3, exp4};
    for (int i = 0; i < 5; i++) check(tag, hand_tiles[i], e[i]);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    step();
    step();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_tile_valid", tile_valid, 1'b0);
    check("rst_tile_last", tile_last, 1'b0);
    check("rst_tile_data", tile_data, 6'h00);
    check("rst_tile_class", tile_class, 2'b00);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", req_ready, 1'b1);
    model_lfsr = 16'hACE1;

    // Seed 0001, one hand per class.
    load_seed(16'h0001);
    get_hand(2'b11, 0, hand_tiles);
    check_tiles("t1_tripair", 'h20, 'h20, 'h20, 'h00, 'h00);
    load_seed(16'h0001);
    get_hand(2'b10, 0, hand_tiles);
    check_tiles("t2_seqpair", 'h20, 'h21, 'h22, 'h00, 'h00);
    load_seed(16'h0001);
    get_hand(2'b00, 0, hand_tiles);
    check_tiles("t2_nowin", 'h20, 'h22, 'h24, 'h26, 'h28);
    load_seed(16'h0001);
    get_hand(2'b01, 0, hand_tiles);
    check_tiles("t2_invalid", 'h2F, 'h22, 'h24, 'h26, 'h28);

    // Back-pressure on tile 2.
    load_seed(16'h0001);
    get_hand(2'b00, 2, hand_tiles);
    check_tiles("t3_backpressure", 'h20, 'h22, 'h24, 'h26, 'h28);

    // Seed 0 maps to 1; seed_load beats req_valid.
    seed_load = 1'b1;
    seed = 16'h0000;
    req_valid = 1'b1;
    req_class = 2'b11;
    #1;
    check("t4_seed_wins_ready", req_ready, 1'b0);
    step();
    seed_load = 1'b0;
    req_valid = 1'b0;
    #1;
    check("t4_no_hand_valid", tile_valid, 1'b0);
    check("t4_still_idle", req_ready, 1'b1);
    step();
    check("t4_no_hand_later", tile_valid, 1'b0);
    model_lfsr = 16'h0001;
    get_hand(2'b11, 0, hand_tiles);
    check_tiles("t4_seed_zero", 'h20, 'h20, 'h20, 'h00, 'h00);

    // Reset during emission.
    load_seed(16'h0001);
    req_valid = 1'b1;
    req_class = 2'b11;
    step();
    req_valid = 1'b0;
    step();
    tile_ready = 1'b1;
    step();
    step();
    check("t5_mid_emit_valid", tile_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_rst_req_ready", req_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("t5_abort_valid", tile_valid, 1'b0);
    check("t5_abort_last", tile_last, 1'b0);
    check("t5_abort_req_ready", req_ready, 1'b1);
    model_lfsr = 16'hACE1;
    get_hand(2'b10, 0, hand_tiles);

    // Random requests, seeds reloaded now and then, random back-pressure.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 15) == 0) load_seed(16'h0000);
        else load_seed(16'($urandom));
      end
      get_hand(2'($urandom_range(0, 3)), int'($urandom_range(0, 1)), hand_tiles);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
